// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the mesh router blocks.
//  - FLIT_W           : default flit width in bits
//  - noc_clog2()      : constant-foldable ceil(log2(n)), used for pointer/count widths
//  - router_port_e    : router port index encoding
package noc_pkg;

  localparam int unsigned FLIT_W = 8;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } router_port_e;

  localparam int unsigned NUM_PORTS = 5;

  // ceil(log2(n)); returns 0 for n <= 1.
  function automatic int unsigned noc_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/noc_fifo_ram.sv
// noc_fifo_ram: DEPTH x DATA_W register file, synchronous write, asynchronous read.
// Contents are not reset.
//  clk    : write clock, rising edge
//  we     : write enable
//  waddr  : write address
//  wdata  : write data
//  raddr  : read address
//  rdata  : combinational read data, mem[raddr]
module noc_fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: router input-buffer FIFO, valid/ready on both sides,
// first-word-fall-through output, occupancy count, almost-full flag,
// synchronous flush and peak-occupancy statistic.
//  clk, rst     : clock (rising edge), asynchronous active-high reset
//  flush        : synchronous clear of pointers, count and peak
//  in_valid/in_ready/in_data    : write handshake
//  out_valid/out_ready/out_data : read handshake, out_data = 0 when empty
//  count        : current occupancy 0..DEPTH
//  almost_full  : count >= AFULL_THRESH
//  peak_count   : maximum occupancy since last rst/flush
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter  int unsigned DATA_W       = FLIT_W,
  parameter  int unsigned DEPTH        = 8,
  parameter  int unsigned AFULL_THRESH = DEPTH - 2,
  localparam int unsigned PTR_W        = noc_clog2(DEPTH),
  localparam int unsigned CNT_W        = noc_clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic [CNT_W-1:0]  peak_count
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  peak_q, peak_d;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_data;

  // Flags come straight from the registered count.
  assign in_ready    = (count_q != CNT_W'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= CNT_W'(AFULL_THRESH));

  assign wr_en = in_valid  & in_ready;
  assign rd_en = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    peak_d   = peak_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      peak_d   = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
      else if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
      // Peak tracks the next count so it is current in the same cycle as count.
      if (count_d > peak_q) peak_d = count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
    end
  end

  noc_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en & ~flush),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign out_data   = out_valid ? rd_data : '0;
  assign count      = count_q;
  assign peak_count = peak_q;

endmodule

// File: tb/tb_noc_flit_fifo.sv
module tb_noc_flit_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       almost_full;
  logic [3:0] peak_count;

  int n_cmp = 0;
  int n_err = 0;

  noc_flit_fifo #(
    .DATA_W       (8),
    .DEPTH        (8),
    .AFULL_THRESH (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
    .peak_count  (peak_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Asynchronous reset asserted mid-cycle
    #12 rst = 1'b1;
    #1;
    chk("rst_in_ready",  32'(in_ready),    32'd1);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_out_data",  32'(out_data),    32'h00);
    chk("rst_count",     32'(count),       32'd0);
    chk("rst_afull",     32'(almost_full), 32'd0);
    chk("rst_peak",      32'(peak_count),  32'd0);
    #9 rst = 1'b0;
    cycle();

    // 2. Fill 0x10..0x17 with no reads
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h10 + i);
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      cycle();
      chk("fill_count", 32'(count),       32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 6));
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'hFF;
    cycle();
    chk("full_ignore_count", 32'(count),    32'd8);
    chk("full_ignore_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // 3. Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data",  32'(out_data),  32'(8'h10 + i));
      cycle();
    end
    chk("drain_out_valid", 32'(out_valid),  32'd0);
    chk("drain_count",     32'(count),      32'd0);
    chk("drain_peak",      32'(peak_count), 32'd8);
    chk("drain_out_data",  32'(out_data),   32'h00);
    out_ready = 1'b0;

    // 4. Preload 3 then stream 12 write+read cycles
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h40 + i);
      cycle();
    end
    chk("pre_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'(8'h43 + i);
      chk("stream_data", 32'(out_data), 32'(8'h40 + i));
      cycle();
      chk("stream_count", 32'(count), 32'd3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stream_tail", 32'(out_data), 32'(8'h4C + i));
      cycle();
    end
    chk("stream_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // 5a. Full with in_valid and out_ready: read only
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h60 + i);
      cycle();
    end
    chk("f5_full", 32'(count), 32'd8);
    in_data   = 8'hEE;
    out_ready = 1'b1;
    cycle();
    chk("f5_count",    32'(count),    32'd7);
    chk("f5_in_ready", 32'(in_ready), 32'd1);
    chk("f5_head",     32'(out_data), 32'h61);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("f5_drain", 32'(out_data), 32'(8'h61 + i));
      cycle();
    end
    chk("f5_empty", 32'(count), 32'd0);

    // 5b. Empty with write+read: only the write fires
    in_valid = 1'b1;
    in_data  = 8'hA5;
    chk("e5_no_pass", 32'(out_valid), 32'd0);
    cycle();
    chk("e5_count", 32'(count),     32'd1);
    chk("e5_valid", 32'(out_valid), 32'd1);
    chk("e5_data",  32'(out_data),  32'hA5);
    in_valid = 1'b0;
    cycle();
    chk("e5_drained", 32'(count), 32'd0);
    out_ready = 1'b0;

    // 6. Flush at count 5 with concurrent write and read
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h70 + i);
      cycle();
    end
    chk("fl_pre_count", 32'(count),      32'd5);
    chk("fl_pre_peak",  32'(peak_count), 32'd8);
    flush     = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b1;
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fl_count",    32'(count),      32'd0);
    chk("fl_valid",    32'(out_valid),  32'd0);
    chk("fl_peak",     32'(peak_count), 32'd0);
    chk("fl_out_data", 32'(out_data),   32'h00);
    chk("fl_in_ready", 32'(in_ready),   32'd1);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    cycle();
    in_valid = 1'b0;
    chk("fl_wr_count", 32'(count),      32'd1);
    chk("fl_wr_data",  32'(out_data),   32'h3C);
    chk("fl_wr_peak",  32'(peak_count), 32'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("fl_rd_count", 32'(count),      32'd0);
    chk("fl_rd_peak",  32'(peak_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
